muxn_skid: RTL

MUXN_SKID -- requirements
Module: muxn_skid

---
 rtl/mux_pkg.sv | 12 +
 rtl/skid_buf.sv | 82 ++++++++
 rtl/muxn_skid.sv | 68 ++++++
 3 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults and select-width helper for the channel mux
package mux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 4;

    // A 2-channel mux still needs one select bit, so never return zero.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - two-entry main/skid register slice with registered upstream ready
module skid_buf
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_ready;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_main_valid_nxt;
    logic [WIDTH-1:0] w_main_data_nxt;
    logic             w_skid_valid_nxt;
    logic [WIDTH-1:0] w_skid_data_nxt;

    assign w_in_xfer  = i_valid && r_in_ready && !i_flush;
    assign w_out_xfer = r_main_valid && i_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        // Main is free to load when empty or emptying; skid always has priority to keep FIFO order.
        if (!r_main_valid || w_out_xfer) begin
            if (r_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end else begin
                w_main_valid_nxt = w_in_xfer;
                if (w_in_xfer) begin
                    w_main_data_nxt = i_data;
                end
            end
        end else if (w_in_xfer) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            // Ready is the registered inverse of skid occupancy, so out_ready never reaches it combinationally.
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign o_ready = r_in_ready;
    assign o_data  = r_main_data;
    assign o_valid = r_main_valid;

endmodule

// File: rtl/muxn_skid.sv
// rtl/muxn_skid.sv - N-channel select mux feeding a two-entry skid buffer, with sticky bad-select flag
module muxn_skid
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SEL_W = sel_w(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               flush,
    output logic               sel_err,
    input  logic               err_clr
);

    logic [WIDTH-1:0] w_word;
    logic             w_sel_ok;
    logic             w_in_xfer;
    logic             r_sel_err;

    // Out-of-range selects fall back to channel 0 instead of indexing past the bus.
    always_comb begin
        w_word   = in_data[WIDTH-1:0];
        w_sel_ok = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_word   = in_data[k*WIDTH +: WIDTH];
                w_sel_ok = 1'b1;
            end
        end
    end

    assign w_in_xfer = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (w_in_xfer && !w_sel_ok) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign sel_err = r_sel_err;

    skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_data  (w_word),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_data  (out_data),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

endmodule
